pc_sequencer: RTL and testbench

Parametrised program-counter sequencer for the single-cycle/pipelined ARM datapath. It holds the fetch address and selects the next address each clock: sequential increment, PC-relative branch, absolute jump, or stall. It can also push return addresses on calls and pop them on returns. It sits in front of instruction memory and is driven by the control unit and the branch/ALU logic.

---
 rtl/pc_sequencer_if.sv | 37 +++
 rtl/pc_sequencer.sv | 146 ++++++++++++++
 tb/tb_pc_sequencer.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer_if
// Description : Request/response bundle between the control unit (master)
//               and the program-counter sequencer (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_sequencer_if #(
  parameter int WIDTH    = 32,
  parameter int OFFSET_W = 24
);
  // Requests from the control unit / branch logic
  logic                STALL;
  logic                BRANCH;
  logic [OFFSET_W-1:0] OFFSET;
  logic                JUMP;
  logic [WIDTH-1:0]    TARGET;
  logic                CALL;
  logic                RET;
  // Sequencer state seen by instruction fetch
  logic [WIDTH-1:0]    PC;
  logic [WIDTH-1:0]    PC_SEQ;
  logic                RAS_EMPTY;
  logic                RAS_FULL;
  logic                RAS_UNDERFLOW;

  modport master (
    output STALL, BRANCH, OFFSET, JUMP, TARGET, CALL, RET,
    input  PC, PC_SEQ, RAS_EMPTY, RAS_FULL, RAS_UNDERFLOW
  );

  modport slave (
    input  STALL, BRANCH, OFFSET, JUMP, TARGET, CALL, RET,
    output PC, PC_SEQ, RAS_EMPTY, RAS_FULL, RAS_UNDERFLOW
  );
endinterface
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Program-counter sequencer. Selects the next fetch address
//               each clock (stall / jump / return / branch / increment) and
//               optionally keeps a circular return-address stack.
//               Optional feature macro: PC_RAS_EN (return-address stack).
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
  parameter int               WIDTH        = 32,
  parameter int               OFFSET_W     = 24,
  parameter logic [WIDTH-1:0] RESET_VECTOR = {{(WIDTH-2){1'b1}}, 2'b00},
  parameter int               RAS_DEPTH    = 4
) (
  input wire              CLK,
  input wire              RESET,
  pc_sequencer_if.slave   bus
);

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] w_pc_seq;
  logic [WIDTH-1:0] w_off_ext;
  logic [WIDTH-1:0] w_branch_tgt;
  logic [WIDTH-1:0] w_target_al;
  logic [WIDTH-1:0] w_pc_next;

  // Offset is sign-extended (or truncated) to the PC width before the word shift
  assign w_off_ext    = WIDTH'($signed(bus.OFFSET));
  assign w_pc_seq     = r_pc + WIDTH'(4);
  assign w_branch_tgt = w_pc_seq + (w_off_ext << 2);
  assign w_target_al  = {bus.TARGET[WIDTH-1:2], 2'b00};

  assign bus.PC     = r_pc;
  assign bus.PC_SEQ = w_pc_seq;

`ifdef PC_RAS_EN
  localparam int PTR_W = $clog2(RAS_DEPTH);

  // r_ptr indexes the next free slot; when full it also points at the oldest
  // entry, so a push naturally overwrites it.
  logic [WIDTH-1:0] r_ras [RAS_DEPTH];
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W:0]   r_count;
  logic             r_underflow;
  logic [PTR_W-1:0] w_top_idx;
  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic             w_underflow_next;
  logic             w_unused;

  assign w_top_idx = r_ptr - 1'b1;
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == (PTR_W+1)'(RAS_DEPTH));
  assign w_unused  = &{1'b0, bus.TARGET[1:0]};

  assign bus.RAS_EMPTY     = w_empty;
  assign bus.RAS_FULL      = w_full;
  assign bus.RAS_UNDERFLOW = r_underflow;

  // Next-PC and stack-operation selection in priority order jump > ret > branch
  always_comb begin
    w_pc_next        = w_pc_seq;
    w_push           = 1'b0;
    w_pop            = 1'b0;
    w_underflow_next = 1'b0;
    if (bus.JUMP) begin
      w_pc_next = w_target_al;
      w_push    = bus.CALL;
    end else if (bus.RET) begin
      if (!w_empty) begin
        w_pc_next = r_ras[w_top_idx];
        w_pop     = 1'b1;
      end else begin
        w_pc_next        = w_target_al;
        w_underflow_next = 1'b1;
      end
    end else if (bus.BRANCH) begin
      w_pc_next = w_branch_tgt;
    end
  end

  // PC, stack pointer/count and underflow flag; everything holds while stalled
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_pc        <= RESET_VECTOR;
      r_ptr       <= '0;
      r_count     <= '0;
      r_underflow <= 1'b0;
    end else if (bus.STALL) begin
      r_underflow <= 1'b0;
    end else begin
      r_pc        <= w_pc_next;
      r_underflow <= w_underflow_next;
      if (w_push) begin
        r_ptr <= r_ptr + 1'b1;
        if (!w_full) begin
          r_count <= r_count + 1'b1;
        end
      end else if (w_pop) begin
        r_ptr   <= w_top_idx;
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Stack storage needs no reset; the count decides which entries are valid
  always_ff @(posedge CLK) begin
    if (RESET && !bus.STALL && w_push) begin
      r_ras[r_ptr] <= w_pc_seq;
    end
  end

`else
  logic w_unused;

  assign w_unused = &{1'b0, bus.TARGET[1:0], bus.CALL, RAS_DEPTH[0]};

  assign bus.RAS_EMPTY     = 1'b1;
  assign bus.RAS_FULL      = 1'b0;
  assign bus.RAS_UNDERFLOW = 1'b0;

  // Next-PC selection; without a stack a return is just a jump to TARGET
  always_comb begin
    w_pc_next = w_pc_seq;
    if (bus.JUMP || bus.RET) begin
      w_pc_next = w_target_al;
    end else if (bus.BRANCH) begin
      w_pc_next = w_branch_tgt;
    end
  end

  // PC register; holds while stalled
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_pc <= RESET_VECTOR;
    end else if (!bus.STALL) begin
      r_pc <= w_pc_next;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Self-checking bench for pc_sequencer: directed vector table,
//               hand-written stack sequences and randomized stimulus against
//               a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;
  localparam int WIDTH    = 32;
  localparam int OFFSET_W = 24;
  localparam int DEPTH    = 4;
`ifdef PC_RAS_EN
  localparam bit C_RAS = 1'b1;
`else
  localparam bit C_RAS = 1'b0;
`endif

  logic CLK   = 1'b0;
  logic RESET = 1'b0;
  always #5 CLK = ~CLK;

  pc_sequencer_if #(.WIDTH(WIDTH), .OFFSET_W(OFFSET_W)) sif ();

  pc_sequencer #(
    .WIDTH        (WIDTH),
    .OFFSET_W     (OFFSET_W),
    .RESET_VECTOR (32'hFFFF_FFFC),
    .RAS_DEPTH    (DEPTH)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (sif)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: architectural PC plus a bounded list of return addresses
  logic [31:0] m_pc;
  logic [31:0] m_stack [$];
  logic        m_uf;

  typedef struct {
    logic        stall;
    logic        branch;
    logic [23:0] off;
    logic        jump;
    logic [31:0] tgt;
    logic        call;
    logic        ret;
    logic [31:0] exp_pc;
    logic        exp_uf;
  } vec_t;

  vec_t vecs [$];

  function automatic vec_t mk(logic s, logic b, logic [23:0] o, logic j,
                              logic [31:0] t, logic c, logic r,
                              logic [31:0] epc, logic euf);
    vec_t v;
    v.stall = s; v.branch = b; v.off = o; v.jump = j; v.tgt = t;
    v.call = c; v.ret = r; v.exp_pc = epc; v.exp_uf = euf;
    return v;
  endfunction

  task automatic model_reset();
    m_pc = 32'hFFFF_FFFC;
    m_stack.delete();
    m_uf = 1'b0;
  endtask

  task automatic model_step(input logic stall, branch, input logic [23:0] off,
                            input logic jump, input logic [31:0] tgt,
                            input logic call, ret);
    logic [31:0] seq;
    int          o;
    if (stall) begin
      m_uf = 1'b0;
      return;
    end
    seq  = m_pc + 32'd4;
    m_uf = 1'b0;
    if (jump) begin
      if (C_RAS && call) begin
        m_stack.push_back(seq);
        if (m_stack.size() > DEPTH) m_stack.delete(0);
      end
      m_pc = tgt & 32'hFFFF_FFFC;
    end else if (ret) begin
      if (C_RAS && m_stack.size() > 0) begin
        m_pc = m_stack.pop_back();
      end else begin
        m_pc = tgt & 32'hFFFF_FFFC;
        m_uf = C_RAS;
      end
    end else if (branch) begin
      o    = (int'(off) >= 8388608) ? int'(off) - 16777216 : int'(off);
      m_pc = seq + 32'(o * 4);
    end else begin
      m_pc = seq;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_pc"},     sif.PC, m_pc);
    chk({tag, "_pc_seq"}, sif.PC_SEQ, m_pc + 32'd4);
    chk({tag, "_empty"},  {31'b0, sif.RAS_EMPTY}, {31'b0, m_stack.size() == 0});
    chk({tag, "_full"},   {31'b0, sif.RAS_FULL}, {31'b0, m_stack.size() == DEPTH});
    chk({tag, "_uf"},     {31'b0, sif.RAS_UNDERFLOW}, {31'b0, m_uf});
  endtask

  // Drive one request, clock it in, advance the model, then settle for sampling
  task automatic step(input logic stall, branch, input logic [23:0] off,
                      input logic jump, input logic [31:0] tgt,
                      input logic call, ret);
    sif.STALL  = stall;
    sif.BRANCH = branch;
    sif.OFFSET = off;
    sif.JUMP   = jump;
    sif.TARGET = tgt;
    sif.CALL   = call;
    sif.RET    = ret;
    @(posedge CLK);
    model_step(stall, branch, off, jump, tgt, call, ret);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 24'h0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] ret_exp [4];

    sif.STALL = 1'b0; sif.BRANCH = 1'b0; sif.OFFSET = '0; sif.JUMP = 1'b0;
    sif.TARGET = '0;  sif.CALL = 1'b0;   sif.RET = 1'b0;
    model_reset();

    // Reset state
    #12;
    chk("rst_pc",     sif.PC, 32'hFFFF_FFFC);
    chk("rst_pc_seq", sif.PC_SEQ, 32'h0000_0000);
    chk("rst_empty",  {31'b0, sif.RAS_EMPTY}, 32'd1);
    chk("rst_full",   {31'b0, sif.RAS_FULL}, 32'd0);
    chk("rst_uf",     {31'b0, sif.RAS_UNDERFLOW}, 32'd0);
    RESET = 1'b1;

    // Directed table (valid in both configurations; stack stays empty)
    vecs.push_back(mk(0,0,24'h0,     0,32'h0,        0,0, 32'h0000_0000, 0));
    vecs.push_back(mk(0,0,24'h0,     0,32'h0,        0,0, 32'h0000_0004, 0));
    vecs.push_back(mk(0,0,24'h0,     0,32'h0,        0,0, 32'h0000_0008, 0));
    vecs.push_back(mk(0,0,24'h0,     1,32'h103,      0,0, 32'h0000_0100, 0));
    vecs.push_back(mk(0,1,24'hFFFFFE,0,32'h0,        0,0, 32'h0000_00FC, 0));
    vecs.push_back(mk(0,0,24'h0,     1,32'h100,      0,0, 32'h0000_0100, 0));
    vecs.push_back(mk(0,1,24'h000003,0,32'h0,        0,0, 32'h0000_0110, 0));
    vecs.push_back(mk(1,0,24'h0,     1,32'h2003,     0,0, 32'h0000_0110, 0));
    vecs.push_back(mk(1,0,24'h0,     1,32'h2003,     0,0, 32'h0000_0110, 0));
    vecs.push_back(mk(1,0,24'h0,     1,32'h2003,     0,0, 32'h0000_0110, 0));
    vecs.push_back(mk(0,0,24'h0,     1,32'h2003,     0,0, 32'h0000_2000, 0));
    vecs.push_back(mk(0,1,24'h000001,0,32'h302,      0,1, 32'h0000_0300, C_RAS));
    vecs.push_back(mk(0,0,24'h0,     0,32'h0,        0,0, 32'h0000_0304, 0));
    vecs.push_back(mk(0,0,24'h0,     1,32'hFFFFFFFF, 0,0, 32'hFFFF_FFFC, 0));
    vecs.push_back(mk(0,0,24'h0,     0,32'h0,        0,0, 32'h0000_0000, 0));
    vecs.push_back(mk(0,0,24'h0,     0,32'h0,        1,0, 32'h0000_0004, 0));
    vecs.push_back(mk(0,1,24'hFFFFFF,0,32'h0,        0,0, 32'h0000_0004, 0));
    vecs.push_back(mk(0,1,24'h800000,0,32'h0,        0,0, 32'hFE00_0008, 0));
    vecs.push_back(mk(1,0,24'h0,     0,32'h0,        0,1, 32'hFE00_0008, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].stall, vecs[i].branch, vecs[i].off, vecs[i].jump,
           vecs[i].tgt, vecs[i].call, vecs[i].ret);
      chk($sformatf("vec%0d_pc", i), sif.PC, vecs[i].exp_pc);
      chk($sformatf("vec%0d_pc_seq", i), sif.PC_SEQ, vecs[i].exp_pc + 32'd4);
      chk($sformatf("vec%0d_uf", i), {31'b0, sif.RAS_UNDERFLOW}, {31'b0, vecs[i].exp_uf});
      chk($sformatf("vec%0d_empty", i), {31'b0, sif.RAS_EMPTY}, 32'd1);
    end

`ifdef PC_RAS_EN
    // Call then return
    step(0,0,24'h0,1,32'h40,0,0);
    chk("call_pre_pc", sif.PC, 32'h40);
    step(0,0,24'h0,1,32'h800,1,0);
    chk("call_pc", sif.PC, 32'h800);
    chk("call_empty", {31'b0, sif.RAS_EMPTY}, 32'd0);
    idle();
    step(0,0,24'h0,0,32'h123,0,1);
    chk("ret_pc", sif.PC, 32'h44);
    chk("ret_empty", {31'b0, sif.RAS_EMPTY}, 32'd1);

    // Five calls into a four-deep stack, then five returns
    for (int i = 0; i < 5; i++) begin
      step(0,0,24'h0,1,32'(i * 16),0,0);
      step(0,0,24'h0,1,32'h800,1,0);
      if (i == 2) chk("ovf_full3", {31'b0, sif.RAS_FULL}, 32'd0);
      if (i == 3) chk("ovf_full4", {31'b0, sif.RAS_FULL}, 32'd1);
    end
    chk("ovf_full5", {31'b0, sif.RAS_FULL}, 32'd1);
    ret_exp[0] = 32'h44; ret_exp[1] = 32'h34; ret_exp[2] = 32'h24; ret_exp[3] = 32'h14;
    for (int i = 0; i < 4; i++) begin
      step(0,0,24'h0,0,32'h555,0,1);
      chk($sformatf("pop%0d_pc", i), sif.PC, ret_exp[i]);
      chk($sformatf("pop%0d_uf", i), {31'b0, sif.RAS_UNDERFLOW}, 32'd0);
    end
    step(0,0,24'h0,0,32'h555,0,1);
    chk("udf_pc", sif.PC, 32'h554);
    chk("udf_uf", {31'b0, sif.RAS_UNDERFLOW}, 32'd1);
    chk("udf_empty", {31'b0, sif.RAS_EMPTY}, 32'd1);
    idle();
    chk("udf_pulse_end", {31'b0, sif.RAS_UNDERFLOW}, 32'd0);
    chk("udf_next_pc", sif.PC, 32'h558);
`else
    // Without a stack, CALL is inert and RET is a plain jump
    step(0,0,24'h0,1,32'h800,1,0);
    chk("nocall_pc", sif.PC, 32'h800);
    chk("nocall_empty", {31'b0, sif.RAS_EMPTY}, 32'd1);
    step(0,0,24'h0,0,32'h300,0,1);
    chk("noret_pc", sif.PC, 32'h300);
    chk("noret_empty", {31'b0, sif.RAS_EMPTY}, 32'd1);
    chk("noret_uf", {31'b0, sif.RAS_UNDERFLOW}, 32'd0);
`endif

    // Asynchronous reset mid-cycle, no clock edge needed
    #3;
    RESET = 1'b0;
    #1;
    chk("async_pc", sif.PC, 32'hFFFF_FFFC);
    chk("async_pc_seq", sif.PC_SEQ, 32'h0);
    chk("async_empty", {31'b0, sif.RAS_EMPTY}, 32'd1);
    model_reset();
    @(negedge CLK);
    RESET = 1'b1;
    idle();
    chk("after_async_pc", sif.PC, 32'h0);

    // Randomized stimulus against the reference model
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic        s, b, j, c, r;
      logic [23:0] o;
      logic [31:0] t;
      s = ($urandom_range(0, 7) == 0);
      j = ($urandom_range(0, 4) == 0);
      c = ($urandom_range(0, 1) == 0);
      r = ($urandom_range(0, 4) == 0);
      b = ($urandom_range(0, 2) == 0);
      o = ($urandom_range(0, 1) == 0) ? 24'($urandom) : 24'($urandom_range(0, 31)) - 24'd16;
      t = 32'($urandom);
      step(s, b, o, j, t, c, r);
      chk_model($sformatf("rnd%0d", cyc));
      if (cyc == 300) begin
        #2;
        RESET = 1'b0;
        #1;
        model_reset();
        chk_model("rnd_async");
        @(negedge CLK);
        RESET = 1'b1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
